// File: rtl/mmio_bridge.sv
// mmio_bridge: CPU bus bridge to RAM, a TX FIFO, an external RX FIFO and a cycle counter.
module mmio_bridge #(
  parameter int TX_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_rdy,
  output logic [16:0] ram_a,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        rx_pop,
  output logic        prog_end
);
  localparam int PW = $clog2(TX_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(TX_DEPTH);
  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_BYTE} src_t;
  src_t src_q, src_d;
  logic [7:0] byte_q, byte_d, io_byte;
  logic [31:0] cnt_q, cnt_d, shadow_q, shadow_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0] count_q, count_d;
  logic prog_q, prog_d;
  logic [7:0] mem_q [TX_DEPTH];
  logic io, wr_tx, wr_end, rd_rx, rd_acc, acc, push, pop;
  logic [15:0] off;
  logic unused_hi;
  assign unused_hi = ^cpu_a[31:18];
  assign io = cpu_a[17:16] == 2'b11;
  assign off = cpu_a[15:0];
  assign wr_tx = io && cpu_wr && off == 16'h0 && cpu_dout != 8'h0;
  assign wr_end = io && cpu_wr && off == 16'h4;
  assign rd_rx = io && !cpu_wr && off == 16'h0;
  // Held in reset so the CPU never sees a stall while the bridge is cleared.
  assign cpu_rdy = !rst_in || !(((wr_tx || wr_end) && count_q == FULL) || (rd_rx && rx_empty));
  assign acc = rst_in && cpu_rdy;
  assign rd_acc = acc && !cpu_wr;
  assign push = acc && (wr_tx || wr_end);
  assign pop = tx_valid && tx_ready;
  assign ram_a = cpu_a[16:0];
  assign ram_wdata = cpu_dout;
  assign ram_we = acc && cpu_wr && !io;
  assign rx_pop = acc && rd_rx;
  assign tx_valid = count_q != '0;
  assign tx_data = mem_q[rp_q];
  assign prog_end = prog_q;
  // RAM data arrives a cycle late, so it is muxed live; everything else is latched in byte_q.
  assign cpu_din = src_q == SRC_RAM ? ram_rdata : src_q == SRC_BYTE ? byte_q : 8'h0;
  assign io_byte = rd_rx ? rx_data :
                   off == 16'h4 ? cnt_q[7:0] :
                   off == 16'h5 ? shadow_q[15:8] :
                   off == 16'h6 ? shadow_q[23:16] :
                   off == 16'h7 ? shadow_q[31:24] : 8'h0;
  always_comb begin
    src_d = rd_acc && !io ? SRC_RAM : SRC_BYTE;
    byte_d = rd_acc && io ? io_byte : cpu_din;
    shadow_d = rd_acc && io && off == 16'h4 ? cnt_q : shadow_q;
    cnt_d = cnt_q + 32'd1;
    prog_d = prog_q || (push && wr_end);
    wp_d = wp_q + PW'(push);
    rp_d = rp_q + PW'(pop);
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      src_q <= SRC_ZERO;
      byte_q <= 8'h0;
      shadow_q <= 32'h0;
      cnt_q <= 32'h0;
      prog_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
    end else begin
      src_q <= src_d;
      byte_q <= byte_d;
      shadow_q <= shadow_d;
      cnt_q <= cnt_d;
      prog_q <= prog_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wp_q] <= wr_tx ? cpu_dout : 8'h0;
  end
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed and random checks of mmio_bridge against a queue-based model.
module tb_mmio_bridge;
  logic clk_in = 1'b0, rst_in = 1'b1;
  logic [31:0] cpu_a = 32'h0003_0008;
  logic cpu_wr = 1'b1, tx_ready = 1'b0, rx_empty = 1'b1;
  logic [7:0] cpu_dout = 8'h0, ram_rdata = 8'h0, rx_data = 8'h0;
  logic [7:0] cpu_din, tx_data, ram_wdata;
  logic [16:0] ram_a;
  logic cpu_rdy, ram_we, tx_valid, rx_pop, prog_end;

  mmio_bridge #(.TX_DEPTH(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .cpu_rdy(cpu_rdy), .ram_a(ram_a), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_empty(rx_empty), .rx_pop(rx_pop), .prog_end(prog_end)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0, errors = 0, pops = 0;
  logic [7:0] m_q[$];
  logic [7:0] emitted[$];
  logic [7:0] m_byte = 8'h0;
  logic [31:0] m_cyc = 32'h0, m_shadow = 32'h0;
  logic m_pend_ram = 1'b0, m_prog = 1'b0;
  logic o_rdy = 1'b1, o_we, o_pop, o_valid, o_prog;
  logic [7:0] o_din, o_tx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input logic [31:0] a, input logic wr, input logic [7:0] d);
    cpu_a = a;
    cpu_wr = wr;
    cpu_dout = d;
  endtask

  task automatic idle();
    set_cpu(32'h0003_0008, 1'b1, 8'h0);
  endtask

  // One clock: compare every output with the model at the falling edge, then advance the model.
  task automatic step();
    logic io_m, rdy_m, full_m;
    logic [15:0] offm;
    logic [7:0] edin;
    @(negedge clk_in);
    io_m = cpu_a[17:16] == 2'b11;
    offm = cpu_a[15:0];
    full_m = m_q.size() == 8;
    edin = m_pend_ram ? ram_rdata : m_byte;
    rdy_m = !(io_m && ((cpu_wr && ((offm == 16'h0 && cpu_dout != 8'h0) || offm == 16'h4) && full_m)
                       || (!cpu_wr && offm == 16'h0 && rx_empty)));
    o_rdy = cpu_rdy; o_din = cpu_din; o_we = ram_we; o_pop = rx_pop;
    o_valid = tx_valid; o_tx = tx_data; o_prog = prog_end;
    chk("cpu_rdy", cpu_rdy, rdy_m);
    chk("cpu_din", cpu_din, edin);
    chk("ram_we", ram_we, cpu_wr && !io_m);
    chk("rx_pop", rx_pop, rdy_m && io_m && !cpu_wr && offm == 16'h0);
    chk("tx_valid", tx_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("tx_data", tx_data, m_q[0]);
    chk("prog_end", prog_end, m_prog);
    chk("ram_a", ram_a, cpu_a[16:0]);
    chk("ram_wdata", ram_wdata, cpu_dout);
    if (tx_valid && tx_ready) emitted.push_back(tx_data);
    if (rx_pop) pops++;
    if (m_q.size() != 0 && tx_ready) void'(m_q.pop_front());
    if (rdy_m && io_m && cpu_wr && offm == 16'h0 && cpu_dout != 8'h0) m_q.push_back(cpu_dout);
    if (rdy_m && io_m && cpu_wr && offm == 16'h4) begin
      m_q.push_back(8'h0);
      m_prog = 1'b1;
    end
    if (rdy_m && !cpu_wr) begin
      m_pend_ram = !io_m;
      if (io_m) begin
        case (offm)
          16'h0: m_byte = rx_data;
          16'h4: begin m_byte = m_cyc[7:0]; m_shadow = m_cyc; end
          16'h5: m_byte = m_shadow[15:8];
          16'h6: m_byte = m_shadow[23:16];
          16'h7: m_byte = m_shadow[31:24];
          default: m_byte = 8'h0;
        endcase
      end
    end else begin
      m_pend_ram = 1'b0;
      m_byte = edin;
    end
    m_cyc = m_cyc + 32'd1;
    @(posedge clk_in);
    #1;
  endtask

  // Reset is applied mid-cycle with a would-stall RX read on the bus.
  task automatic do_reset();
    set_cpu(32'h0003_0000, 1'b0, 8'h0);
    rx_empty = 1'b1;
    rst_in = 1'b0;
    #1;
    chk("rst tx_valid", tx_valid, 1'b0);
    chk("rst cpu_din", cpu_din, 8'h0);
    chk("rst prog_end", prog_end, 1'b0);
    chk("rst cpu_rdy", cpu_rdy, 1'b1);
    chk("rst rx_pop", rx_pop, 1'b0);
    chk("rst ram_we", ram_we, 1'b0);
    m_q.delete();
    m_byte = 8'h0; m_cyc = 32'h0; m_shadow = 32'h0; m_pend_ram = 1'b0; m_prog = 1'b0;
    idle();
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();
    // counter snapshot: cycle 0 is the first cycle after release
    repeat (32'h1234) step();
    set_cpu(32'h0003_0004, 1'b0, 8'h0);
    step();
    set_cpu(32'h0003_0005, 1'b0, 8'h0);
    step();
    chk("cnt low byte", o_din, 8'h34);
    idle();
    step();
    chk("shadow byte1", o_din, 8'h12);
    // TX writes, zero byte dropped
    tx_ready = 1'b1;
    emitted.delete();
    set_cpu(32'h0003_0000, 1'b1, 8'h41); step();
    set_cpu(32'h0003_0000, 1'b1, 8'h00); step();
    set_cpu(32'h0003_0000, 1'b1, 8'h42); step();
    idle();
    repeat (3) step();
    chk("tx emit count", emitted.size(), 2);
    if (emitted.size() == 2) begin
      chk("tx emit0", emitted[0], 8'h41);
      chk("tx emit1", emitted[1], 8'h42);
    end
    // FIFO full stall
    tx_ready = 1'b0;
    emitted.delete();
    for (int i = 0; i < 9; i++) begin
      set_cpu(32'h0003_0000, 1'b1, 8'(8'h61 + i));
      step();
    end
    chk("full stall", o_rdy, 1'b0);
    tx_ready = 1'b1;
    step();
    chk("full stall drain", o_rdy, 1'b0);
    step();
    chk("full accept", o_rdy, 1'b1);
    idle();
    repeat (12) step();
    chk("full emit count", emitted.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < emitted.size()) chk("full emit order", emitted[i], 8'(8'h61 + i));
    // RX read waits for data
    pops = 0;
    rx_data = 8'h00;
    rx_empty = 1'b1;
    set_cpu(32'h0003_0000, 1'b0, 8'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rx stall", o_rdy, 1'b0);
      chk("rx no pop", o_pop, 1'b0);
    end
    rx_data = 8'h5A;
    rx_empty = 1'b0;
    step();
    chk("rx accept", o_rdy, 1'b1);
    chk("rx pop", o_pop, 1'b1);
    idle();
    rx_empty = 1'b1;
    step();
    chk("rx data", o_din, 8'h5A);
    chk("rx pop count", pops, 1);
    // program end
    tx_ready = 1'b0;
    set_cpu(32'h0003_0004, 1'b1, 8'h99);
    step();
    idle();
    step();
    chk("prog_end set", o_prog, 1'b1);
    chk("prog_end byte valid", o_valid, 1'b1);
    chk("prog_end byte", o_tx, 8'h00);
    tx_ready = 1'b1;
    repeat (3) step();
    chk("prog_end sticky", o_prog, 1'b1);
    do_reset();
    // RAM write then read
    set_cpu(32'h0000_0010, 1'b1, 8'h77);
    step();
    chk("ram we pulse", o_we, 1'b1);
    set_cpu(32'h0000_0010, 1'b0, 8'h0);
    step();
    chk("ram we read", o_we, 1'b0);
    idle();
    ram_rdata = 8'h77;
    step();
    chk("ram rdata", o_din, 8'h77);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_cpu(32'h0003_0000, 1'b1, 8'(8'hC0 + i));
      step();
    end
    idle();
    step();
    chk("queued valid", o_valid, 1'b1);
    do_reset();
    step();
    // random traffic; a stalled request is held until accepted
    for (int n = 0; n < 1500; n++) begin
      if (o_rdy) begin
        logic [31:0] a;
        a = $urandom;
        case ($urandom_range(0, 4))
          0: a[17:16] = 2'($urandom_range(0, 2));
          1: a[17:0] = 18'h30000;
          2: a[17:0] = 18'h30004 + 18'($urandom_range(0, 3));
          3: a[17:0] = 18'h30000 + 18'($urandom_range(0, 65535));
          default: a[17:0] = 18'h30000 + 18'($urandom_range(0, 8));
        endcase
        set_cpu(a, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0 ? 8'h0 : 8'($urandom));
      end
      tx_ready = $urandom_range(0, 2) == 0;
      rx_empty = $urandom_range(0, 2) == 0;
      rx_data = 8'($urandom);
      ram_rdata = 8'($urandom);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
